// File: rtl/fifo_stream_ctrl.sv
// Stream-side command controller for the convolution result FIFO: turns a valid/ready input
// stream into FIFO write/read commands and re-streams the registered read data downstream.
module fifo_stream_ctrl #(
  parameter int unsigned data_width = 20,
  parameter int unsigned fifo_depth = 3,
  localparam int unsigned cnt_w = $clog2(fifo_depth + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            fifo_command,
  output logic [data_width-1:0] fifo_wr_data,
  input  logic [data_width-1:0] fifo_rd_data,
  input  logic [1:0]            fifo_status,
  output logic [cnt_w-1:0]      occupancy,
  output logic                  err
);

  typedef enum logic {
    GrantWrite,
    GrantRead
  } grant_e;

  localparam logic [cnt_w-1:0] DepthCnt = cnt_w'(fifo_depth);

  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  wr_req;
  logic                  rd_req;
  logic                  grant_wr;
  logic                  grant_rd;
  logic [2:0]            ob_committed;

  grant_e                last_grant_q, last_grant_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic                  rd_inflight_q;
  logic [data_width-1:0] ob_q [2];
  logic [data_width-1:0] ob_d [2];
  logic [cnt_w-1:0]      occ_q, occ_d;
  logic                  err_q, err_d;

  assign full  = fifo_status[1];
  assign empty = fifo_status[0];
  assign pop   = out_valid && out_ready;

  // Words the output buffer is already committed to hold once the in-flight read lands.
  assign ob_committed = {1'b0, ob_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};

  assign wr_req = !reset && in_valid && !full;
  assign rd_req = !reset && !empty && (ob_committed < 3'd2);

  // Contested cycles go to whichever side did not win last time.
  assign grant_wr = wr_req && (!rd_req || (last_grant_q == GrantRead));
  assign grant_rd = rd_req && !grant_wr;

  assign in_ready     = grant_wr;
  assign fifo_command = {grant_wr, grant_rd};
  assign fifo_wr_data = in_data;

  assign out_valid = (ob_cnt_q != 2'd0);
  assign out_data  = ob_q[0];
  assign occupancy = occ_q;
  assign err       = err_q;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_wr) begin
      last_grant_d = GrantWrite;
    end else if (grant_rd) begin
      last_grant_d = GrantRead;
    end
  end

  // Two-entry in-order output buffer; entry 0 is the head.
  always_comb begin
    ob_d[0]  = ob_q[0];
    ob_d[1]  = ob_q[1];
    ob_cnt_d = ob_cnt_q;
    case ({rd_inflight_q, pop})
      2'b01: begin
        ob_d[0]  = ob_q[1];
        ob_cnt_d = ob_cnt_q - 2'd1;
      end
      2'b10: begin
        if (ob_cnt_q == 2'd0) begin
          ob_d[0] = fifo_rd_data;
        end else begin
          ob_d[1] = fifo_rd_data;
        end
        ob_cnt_d = ob_cnt_q + 2'd1;
      end
      2'b11: begin
        if (ob_cnt_q == 2'd1) begin
          ob_d[0] = fifo_rd_data;
        end else begin
          ob_d[0] = ob_q[1];
          ob_d[1] = fifo_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (grant_wr && (occ_q != DepthCnt)) begin
      occ_d = occ_q + 1'b1;
    end else if (grant_rd && (occ_q != '0)) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if ((full && (occ_q != DepthCnt)) || (empty && (occ_q != '0))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q  <= GrantRead;
      ob_cnt_q      <= 2'd0;
      rd_inflight_q <= 1'b0;
      ob_q[0]       <= '0;
      ob_q[1]       <= '0;
      occ_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      ob_cnt_q      <= ob_cnt_d;
      rd_inflight_q <= grant_rd;
      ob_q[0]       <= ob_d[0];
      ob_q[1]       <= ob_d[1];
      occ_q         <= occ_d;
      err_q         <= err_d;
    end
  end

endmodule
